// File: rtl/ysyx_23060111_sram_resp_if.sv
// ysyx_23060111_sram_resp_if
// Valid/ready bus between a fetch/load-store initiator and the SRAM responder.
// Read channel  : araddr/arvalid/arready, rdata/rresp/rvalid/rready
// Write channel : awaddr/awvalid/awready, wdata/wstrb/wvalid/wready,
//                 bresp/bvalid/bready
// Response codes: 2'b00 OKAY, 2'b11 DECERR.
// master modport = initiator side, slave modport = memory side.
interface ysyx_23060111_sram_resp_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060111_sram_resp.sv
// ysyx_23060111_sram_resp
// Memory-side responder with an internal word array. Serves one read or one
// write at a time and answers after a programmable latency.
// Parameters: BASE  byte address of word 0
//             DEPTH number of 32-bit words (power of two)
//             LAT   cycles from acceptance to response valid (0..15)
// Ports:      clk   rising-edge clock
//             rst   asynchronous reset, active low
//             bus   slave side of ysyx_23060111_sram_resp_if
// Optional:   define YSYX_23060111_SRAM_RAND_DELAY_EN to add 0..3 random
//             extra latency cycles per transaction from an 8-bit LFSR.
// All bus outputs come straight from flops.
module ysyx_23060111_sram_resp #(
  parameter logic [31:0] BASE  = 32'h80000000,
  parameter int          DEPTH = 4096,
  parameter int          LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060111_sram_resp_if.slave    bus
);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;

  typedef enum logic [2:0] {IDLE, RBUSY, RRESP, WBUSY, WRESP} state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        arready_q, arready_d;
  logic        wr_ready_q, wr_ready_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        rd_acc, wr_acc, mem_we;
  logic [4:0]  lat_eff;

  // In IDLE the lookups use the live bus so a zero-latency transaction can
  // complete on its acceptance edge; otherwise they use the latched request.
  logic [31:0] rd_addr, rd_off, rd_word;
  logic        rd_ok;
  logic [1:0]  rd_resp;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0] we_addr, we_off, we_data;
  logic [3:0]  we_strb;
  logic        we_ok;
  logic [1:0]  we_resp;
  logic [IDX_W-1:0] we_idx;

  assign rd_addr = (state_q == IDLE) ? bus.araddr : addr_q;
  assign we_addr = (state_q == IDLE) ? bus.awaddr : addr_q;
  assign we_data = (state_q == IDLE) ? bus.wdata  : wdata_q;
  assign we_strb = (state_q == IDLE) ? bus.wstrb  : wstrb_q;

  // Range check on the full offset so addresses below BASE wrap high and fail.
  assign rd_off  = rd_addr - BASE;
  assign rd_ok   = (rd_addr >= BASE) && ({1'b0, rd_off} < SPAN);
  assign rd_idx  = rd_off[IDX_W+1:2];
  assign rd_word = rd_ok ? mem[rd_idx] : 32'h0;
  assign rd_resp = rd_ok ? 2'b00 : 2'b11;

  assign we_off  = we_addr - BASE;
  assign we_ok   = (we_addr >= BASE) && ({1'b0, we_off} < SPAN);
  assign we_idx  = we_off[IDX_W+1:2];
  assign we_resp = we_ok ? 2'b00 : 2'b11;

`ifdef YSYX_23060111_SRAM_RAND_DELAY_EN
  // Fibonacci LFSR, taps 8,6,5,4; its low two bits stretch each latency.
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= lfsr_d;
  end

  assign lat_eff = 5'(LAT) + {3'b000, lfsr_q[1:0]};
`else
  assign lat_eff = 5'(LAT);
`endif

  // Next-state logic. Write readiness is only offered when a complete write
  // (address and data) is waiting and no read is asking, so a read always
  // wins and a lone address or data beat never sees ready.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    arready_d  = arready_q;
    wr_ready_d = wr_ready_q;
    rvalid_d   = rvalid_q;
    bvalid_d   = bvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bresp_d    = bresp_q;
    rd_acc     = 1'b0;
    wr_acc     = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        arready_d  = 1'b1;
        wr_ready_d = !bus.arvalid && bus.awvalid && bus.wvalid;
        rd_acc     = bus.arvalid && arready_q;
        wr_acc     = !rd_acc && bus.awvalid && bus.wvalid && wr_ready_q;
        if (rd_acc) begin
          arready_d  = 1'b0;
          wr_ready_d = 1'b0;
          addr_d     = bus.araddr;
          cnt_d      = lat_eff;
          if (lat_eff == 5'd0) begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_resp;
          end else begin
            state_d  = RBUSY;
          end
        end else if (wr_acc) begin
          arready_d  = 1'b0;
          wr_ready_d = 1'b0;
          addr_d     = bus.awaddr;
          wdata_d    = bus.wdata;
          wstrb_d    = bus.wstrb;
          cnt_d      = lat_eff;
          if (lat_eff == 5'd0) begin
            state_d  = WRESP;
            bvalid_d = 1'b1;
            bresp_d  = we_resp;
            mem_we   = 1'b1;
          end else begin
            state_d  = WBUSY;
          end
        end
      end
      RBUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = RRESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_word;
          rresp_d  = rd_resp;
        end
      end
      WBUSY: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = WRESP;
          bvalid_d = 1'b1;
          bresp_d  = we_resp;
          mem_we   = 1'b1;
        end
      end
      RRESP: begin
        if (bus.rready) begin
          state_d    = IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          wr_ready_d = !bus.arvalid && bus.awvalid && bus.wvalid;
        end
      end
      WRESP: begin
        if (bus.bready) begin
          state_d    = IDLE;
          bvalid_d   = 1'b0;
          arready_d  = 1'b1;
          wr_ready_d = !bus.arvalid && bus.awvalid && bus.wvalid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      arready_q  <= 1'b0;
      wr_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      bresp_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      arready_q  <= arready_d;
      wr_ready_q <= wr_ready_d;
      rvalid_q   <= rvalid_d;
      bvalid_q   <= bvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
    end
  end

  // Array write happens once, on the edge that enters WRESP. The array is
  // deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && we_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (we_strb[i]) mem[we_idx][8*i +: 8] <= we_data[8*i +: 8];
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.awready = wr_ready_q;
  assign bus.wready  = wr_ready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_ysyx_23060111_sram_resp.sv
// tb_ysyx_23060111_sram_resp
// Three responders with LAT = 1, 3 and 0 share one set of driver variables;
// 'sel' routes the drivers to one instance and its outputs to the monitor.
// A transaction-level model (word store + one pending response with its due
// cycle) is checked against the selected instance on every falling edge.
module tb_ysyx_23060111_sram_resp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rstv;
  int          sel;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  logic [31:0] d_araddr, d_awaddr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready;

  logic        m_arready, m_awready, m_wready, m_rvalid, m_bvalid, m_rst;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  ysyx_23060111_sram_resp_if if0();
  ysyx_23060111_sram_resp_if if1();
  ysyx_23060111_sram_resp_if if2();

  ysyx_23060111_sram_resp #(.LAT(1)) dut0 (.clk(clk), .rst(rstv[0]), .bus(if0));
  ysyx_23060111_sram_resp #(.LAT(3)) dut1 (.clk(clk), .rst(rstv[1]), .bus(if1));
  ysyx_23060111_sram_resp #(.LAT(0)) dut2 (.clk(clk), .rst(rstv[2]), .bus(if2));

  assign if0.araddr  = d_araddr;
  assign if0.awaddr  = d_awaddr;
  assign if0.wdata   = d_wdata;
  assign if0.wstrb   = d_wstrb;
  assign if0.arvalid = d_arvalid && (sel == 0);
  assign if0.rready  = d_rready  && (sel == 0);
  assign if0.awvalid = d_awvalid && (sel == 0);
  assign if0.wvalid  = d_wvalid  && (sel == 0);
  assign if0.bready  = d_bready  && (sel == 0);

  assign if1.araddr  = d_araddr;
  assign if1.awaddr  = d_awaddr;
  assign if1.wdata   = d_wdata;
  assign if1.wstrb   = d_wstrb;
  assign if1.arvalid = d_arvalid && (sel == 1);
  assign if1.rready  = d_rready  && (sel == 1);
  assign if1.awvalid = d_awvalid && (sel == 1);
  assign if1.wvalid  = d_wvalid  && (sel == 1);
  assign if1.bready  = d_bready  && (sel == 1);

  assign if2.araddr  = d_araddr;
  assign if2.awaddr  = d_awaddr;
  assign if2.wdata   = d_wdata;
  assign if2.wstrb   = d_wstrb;
  assign if2.arvalid = d_arvalid && (sel == 2);
  assign if2.rready  = d_rready  && (sel == 2);
  assign if2.awvalid = d_awvalid && (sel == 2);
  assign if2.wvalid  = d_wvalid  && (sel == 2);
  assign if2.bready  = d_bready  && (sel == 2);

  // Route the selected instance's outputs to the monitor signals.
  always_comb begin
    m_arready = if2.arready; m_awready = if2.awready; m_wready = if2.wready;
    m_rvalid  = if2.rvalid;  m_bvalid  = if2.bvalid;  m_rdata  = if2.rdata;
    m_rresp   = if2.rresp;   m_bresp   = if2.bresp;   m_rst    = rstv[2];
    if (sel == 0) begin
      m_arready = if0.arready; m_awready = if0.awready; m_wready = if0.wready;
      m_rvalid  = if0.rvalid;  m_bvalid  = if0.bvalid;  m_rdata  = if0.rdata;
      m_rresp   = if0.rresp;   m_bresp   = if0.bresp;   m_rst    = rstv[0];
    end else if (sel == 1) begin
      m_arready = if1.arready; m_awready = if1.awready; m_wready = if1.wready;
      m_rvalid  = if1.rvalid;  m_bvalid  = if1.bvalid;  m_rdata  = if1.rdata;
      m_rresp   = if1.rresp;   m_bresp   = if1.bresp;   m_rst    = rstv[1];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mmem [int];
  int          pk = 0;
  int          pdue = 0;
  bit          pcommitted = 0;
  logic [31:0] pdata, paddr, pwdata;
  logic [3:0]  pstrb;
  logic [1:0]  presp;

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 0;
  endfunction

  function automatic bit model_ok(input logic [31:0] a);
    return (a >= 32'h80000000) && (a < 32'h80004000);
  endfunction

  function automatic int model_key(input int s, input logic [31:0] a);
    return s * 65536 + int'((a - 32'h80000000) >> 2);
  endfunction

  // Checks the selected instance each falling edge; inputs are stable here,
  // so an acceptance or handshake seen now happens on the next rising edge.
  always @(negedge clk) begin
    if (!m_rst) begin
      pk = 0;
      checkOutput("reset_outputs",
                  {m_arready, m_awready, m_wready, m_rvalid, m_bvalid, m_rdata, m_rresp, m_bresp},
                  64'h0);
    end else if (pk == 1) begin
      checkOutput("rd_arready_low", m_arready, 1'b0);
      checkOutput("rd_write_blocked", {m_awready, m_wready, m_bvalid}, 3'b000);
      if (cyc < pdue) begin
        checkOutput("rvalid_early", m_rvalid, 1'b0);
      end else begin
        checkOutput("rvalid", m_rvalid, 1'b1);
        checkOutput("rdata", m_rdata, pdata);
        checkOutput("rresp", m_rresp, presp);
        if (d_rready) pk = 0;
      end
    end else if (pk == 2) begin
      checkOutput("wr_others_low", {m_arready, m_rvalid}, 2'b00);
      if (cyc < pdue) begin
        checkOutput("bvalid_early", m_bvalid, 1'b0);
      end else begin
        if (!pcommitted && model_ok(paddr)) begin
          logic [31:0] w;
          int k;
          k = model_key(sel, paddr);
          w = mmem.exists(k) ? mmem[k] : 32'h0;
          for (int i = 0; i < 4; i++) if (pstrb[i]) w[8*i +: 8] = pwdata[8*i +: 8];
          mmem[k] = w;
        end
        pcommitted = 1;
        checkOutput("bvalid", m_bvalid, 1'b1);
        checkOutput("bresp", m_bresp, presp);
        if (d_bready) pk = 0;
      end
    end else begin
      checkOutput("idle_no_resp", {m_rvalid, m_bvalid}, 2'b00);
      if (d_arvalid && m_arready) begin
        pk    = 1;
        pdue  = cyc + 1 + lat_of(sel);
        paddr = d_araddr;
        if (model_ok(d_araddr)) begin
          int k;
          k = model_key(sel, d_araddr);
          pdata = mmem.exists(k) ? mmem[k] : 32'h0;
          presp = 2'b00;
        end else begin
          pdata = 32'h0;
          presp = 2'b11;
        end
      end else if (d_awvalid && d_wvalid && m_awready && m_wready) begin
        pk         = 2;
        pdue       = cyc + 1 + lat_of(sel);
        paddr      = d_awaddr;
        pwdata     = d_wdata;
        pstrb      = d_wstrb;
        presp      = model_ok(d_awaddr) ? 2'b00 : 2'b11;
        pcommitted = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit ok;
    data = 32'hDEADDEAD; resp = 2'b01; lat = -1;
    @(posedge clk); #1;
    d_araddr = addr; d_arvalid = 1'b1; d_rready = 1'b0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_arready) begin ok = 1; break; end
    end
    if (!ok) begin
      checkOutput("ar_timeout", 1'b0, 1'b1);
      d_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    d_arvalid = 1'b0;
    lat = 0; ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_rvalid) begin ok = 1; break; end
      lat++;
    end
    if (!ok) begin
      checkOutput("r_timeout", 1'b0, 1'b1);
      return;
    end
    data = m_rdata; resp = m_rresp;
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      checkOutput("hold_rvalid", m_rvalid, 1'b1);
      checkOutput("hold_rdata", m_rdata, data);
      checkOutput("hold_arready", m_arready, 1'b0);
    end
    @(posedge clk); #1;
    d_rready = 1'b1;
    @(posedge clk); #1;
    d_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit ok;
    resp = 2'b01;
    @(posedge clk); #1;
    d_awaddr = addr; d_wdata = data; d_wstrb = strb;
    d_awvalid = 1'b1; d_wvalid = 1'b1; d_bready = 1'b0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_awready && m_wready) begin ok = 1; break; end
    end
    if (!ok) begin
      checkOutput("aw_timeout", 1'b0, 1'b1);
      d_awvalid = 1'b0; d_wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    d_awvalid = 1'b0; d_wvalid = 1'b0;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_bvalid) begin ok = 1; break; end
    end
    if (!ok) begin
      checkOutput("b_timeout", 1'b0, 1'b1);
      return;
    end
    resp = m_bresp;
    @(posedge clk); #1;
    d_bready = 1'b1;
    @(posedge clk); #1;
    d_bready = 1'b0;
  endtask

  // Write and read back, with the literal values worked out by hand.
  task automatic applyStimulus();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          ok, saw_rhs;

    // LAT=1: plain read after a preload of word 1
    sel = 0;
    do_write(32'h80000004, 32'h00009117, 4'hF, r);
    checkOutput("preload_bresp", r, 2'b00);
    do_read(32'h80000004, 0, d, r, lat);
    checkOutput("read1_data", d, 32'h00009117);
    checkOutput("read1_resp", r, 2'b00);
    checkOutput("read1_latency", lat, 1);

    // strobed write merges into the old word
    do_write(32'h80000040, 32'h11223344, 4'hF, r);
    do_write(32'h80000040, 32'hAABBCCDD, 4'b0101, r);
    checkOutput("strb_bresp", r, 2'b00);
    do_read(32'h80000040, 0, d, r, lat);
    checkOutput("strb_data", d, 32'h11BB33DD);

    // decode errors
    do_read(32'h7FFFFFFC, 0, d, r, lat);
    checkOutput("decerr_rdata", d, 32'h0);
    checkOutput("decerr_rresp", r, 2'b11);
    do_write(32'h80000000, 32'h01020304, 4'hF, r);
    do_write(32'h80004000, 32'hFFFFFFFF, 4'hF, r);
    checkOutput("decerr_bresp", r, 2'b11);
    do_read(32'h80000000, 0, d, r, lat);
    checkOutput("decerr_no_write", d, 32'h01020304);

    // backpressure: five cycles of rready low
    do_read(32'h80000040, 5, d, r, lat);
    checkOutput("bp_data", d, 32'h11BB33DD);

    // arbitration: read and write together, read goes first
    @(posedge clk); #1;
    d_araddr = 32'h80000004; d_arvalid = 1'b1; d_rready = 1'b1;
    d_awaddr = 32'h80000044; d_wdata = 32'h55667788; d_wstrb = 4'hF;
    d_awvalid = 1'b1; d_wvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_arready) begin ok = 1; break; end
    end
    checkOutput("arb_ar_seen", ok, 1'b1);
    @(posedge clk); #1;
    d_arvalid = 1'b0;
    ok = 0; saw_rhs = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (m_rvalid && d_rready) saw_rhs = 1;
      if (m_awready && m_wready) begin ok = 1; break; end
    end
    checkOutput("arb_w_seen", ok, 1'b1);
    checkOutput("arb_write_after_read", saw_rhs, 1'b1);
    @(posedge clk); #1;
    d_awvalid = 1'b0; d_wvalid = 1'b0; d_rready = 1'b0; d_bready = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_bvalid) begin ok = 1; break; end
    end
    checkOutput("arb_bvalid_seen", ok, 1'b1);
    @(posedge clk); #1;
    d_bready = 1'b0;
    do_read(32'h80000044, 0, d, r, lat);
    checkOutput("arb_readback", d, 32'h55667788);

    // lone address beat is never taken
    @(posedge clk); #1;
    d_awaddr = 32'h80000048; d_awvalid = 1'b1; d_wvalid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkOutput("lone_awready", m_awready, 1'b0);
      checkOutput("lone_bvalid", m_bvalid, 1'b0);
    end
    @(posedge clk); #1;
    d_awvalid = 1'b0;

    // LAT=3: reset during WBUSY drops the write
    sel = 1;
    do_write(32'h80000100, 32'hCAFEF00D, 4'hF, r);
    @(posedge clk); #1;
    d_awaddr = 32'h80000100; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    d_awvalid = 1'b1; d_wvalid = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_awready && m_wready) begin ok = 1; break; end
    end
    checkOutput("midrst_accept", ok, 1'b1);
    @(posedge clk); #1;
    d_awvalid = 1'b0; d_wvalid = 1'b0;
    @(posedge clk); #1;
    rstv[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checkOutput("midrst_bvalid", m_bvalid, 1'b0);
    end
    @(posedge clk); #1;
    rstv[1] = 1'b1;
    do_read(32'h80000100, 0, d, r, lat);
    checkOutput("midrst_word_kept", d, 32'hCAFEF00D);
    checkOutput("lat3_latency", lat, 3);

    // LAT=0: response right after acceptance
    sel = 2;
    do_write(32'h80000008, 32'h0BADBEEF, 4'hF, r);
    checkOutput("lat0_bresp", r, 2'b00);
    do_read(32'h80000008, 0, d, r, lat);
    checkOutput("lat0_data", d, 32'h0BADBEEF);
    checkOutput("lat0_latency", lat, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstv = 3'b111; sel = 0;
    d_araddr = 32'h0; d_awaddr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    d_arvalid = 1'b0; d_rready = 1'b0; d_awvalid = 1'b0; d_wvalid = 1'b0; d_bready = 1'b0;
    #1 rstv = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rvalid_bvalid", {m_rvalid, m_bvalid, m_arready}, 3'b000);
    @(posedge clk); #1;
    rstv = 3'b111;
    applyStimulus();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ysyx_23060111_sram_resp.md
Name: ysyx_23060111_sram_resp

Overview:
- Memory-side responder for the core's fetch/load-store initiators: a valid/ready, AXI-lite-style slave with an internal word array.
- Accepts one read or one write at a time and returns a response after a programmable latency.
- Replaces the direct combinational memory hookup, so the IFU and LSU can be moved onto handshaked buses.

Parameters:
- BASE, 32'h80000000, byte address of word 0.
- DEPTH, 4096, number of 32-bit words (power of two).
- LAT, 1, cycles from request acceptance to response valid (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- araddr  in  32  read byte address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rdata  out  32  read data.
- rresp  out  2  2'b00 OKAY, 2'b11 DECERR.
- rvalid  out  1  read response valid.
- rready  in  1  initiator takes read response.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address accepted.
- wdata  in  32  write data.
- wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- bresp  out  2  write response, same encoding as rresp.
- bvalid  out  1  write response valid.
- bready  in  1  initiator takes write response.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - arready=awready=wready=0, rvalid=bvalid=0, rdata=0, rresp=bresp=0, latency counter=0.
  - Array contents are not reset.
- Outputs are registered; none depends combinationally on inputs.
- FSM states: IDLE, RBUSY, RRESP, WBUSY, WRESP.
- IDLE:
  - arready=1.
  - awready=wready=1 only when arvalid=0.
- Read accept: arvalid&arready.
  - Latch araddr, load counter with LAT.
  - Go to RBUSY, or straight to RRESP when LAT=0.
  - With LAT=0, rvalid rises the cycle after acceptance.
- Write accept: awvalid&wvalid&awready&wready, in the same cycle only.
  - Latch awaddr, wdata and wstrb.
  - Go to WBUSY, or WRESP when LAT=0.
  - A lone awvalid or lone wvalid is not accepted.
- Simultaneous read and write request: read wins; the write waits, with awready/wready held 0.
- RBUSY/WBUSY:
  - Counter decrements each cycle.
  - At count 1, move to RRESP/WRESP.
  - Effective latency is LAT cycles from the acceptance edge to the valid rising edge.
- RRESP:
  - rvalid=1; rdata and rresp held stable until rvalid&rready.
  - Then go to IDLE and deassert rvalid.
  - arready stays 0 throughout RBUSY/RRESP.
- WRESP:
  - The array write occurs on entry, once, under wstrb.
  - bvalid=1 until bvalid&bready, then IDLE.
- Address decode:
  - index = (addr-BASE)>>2; addr[1:0] is ignored.
  - In range: BASE <= addr < BASE+4*DEPTH.
  - Out of range: resp=2'b11, rdata=0, no array write.
- Back-to-back requests: from IDLE the next acceptance is possible the cycle after the response handshake.
- Maximum throughput is one transaction per LAT+2 cycles.
- Reset mid-transaction: the pending response is dropped. A write still in WBUSY is not performed; a write already in WRESP has already been stored.
- rready/bready asserted while no response is pending are ignored.

Optional Feature:
- Macro: YSYX_23060111_SRAM_RAND_DELAY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5, steps every cycle) adds lfsr[1:0] extra cycles to LAT on each acceptance.
  - Latency is LAT..LAT+3, to stress the initiators' handshakes.
- When undefined: latency is exactly LAT, and no LFSR logic exists.

Test Plan:
- Reset then read: hold rst=0 for 3 cycles, check all outputs 0. Release, LAT=1, araddr=32'h80000004 after a backdoor load of word1=32'h00009117. Expect rvalid 1 cycle after acceptance, rdata=32'h00009117, rresp=0.
- Write/readback with strobes: word 0x80000040 preset to 32'h11223344. Write 32'hAABBCCDD with wstrb=4'b0101, then read it. Expect bresp=0, then rdata=32'h11BB33DD.
- Decode error: read 32'h7FFFFFFC → rresp=2'b11, rdata=0. Write 32'h80004000 (DEPTH=4096) → bresp=2'b11, array unchanged.
- Backpressure and arbitration:
  - Hold rready=0 for 5 cycles after rvalid → rdata stable, arready=0 throughout.
  - Assert arvalid and awvalid+wvalid together → read accepted first; the write is accepted only after the read handshake.
- Lone channel and mid-reset:
  - awvalid=1 with wvalid=0 for 4 cycles → awready never 1.
  - Assert rst=0 during WBUSY with LAT=3 → bvalid=0, target word unchanged.
  - With LAT=0, a read responds the cycle after acceptance.
